// File: rtl/deperf_sync_ctrl.sv
// Deperforator synchronisation controller: judges fixed-length windows of Fano
// decoder error events and slips the puncturing phase until a stable lock is found.
module deperf_sync_ctrl #(
    parameter int WIN_LEN    = 256,
    parameter int ERR_THR    = 32,
    parameter int LOCK_WIN   = 4,
    parameter int UNLOCK_WIN = 4,
    parameter int HOLDOFF    = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_vld,
    input  logic       i_err,
    input  logic       i_resync,
    output logic       o_sh_pointer,
    output logic       o_lock,
    output logic [7:0] o_slip_cnt
);

    typedef enum logic [1:0] {ST_SEARCH, ST_HOLD, ST_LOCKED} state_t;

    localparam logic [15:0] WIN_LAST    = 16'(WIN_LEN - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLDOFF - 1);
    localparam logic [7:0]  LOCK_LAST   = 8'(LOCK_WIN - 1);
    localparam logic [7:0]  UNLOCK_LAST = 8'(UNLOCK_WIN - 1);
    localparam logic [16:0] ERR_LIMIT   = 17'(ERR_THR);

    state_t      state_q, state_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [7:0]  bad_cnt_q, bad_cnt_d;
    logic [7:0]  slip_cnt_q, slip_cnt_d;
    logic        sh_q, sh_d;
    logic        lock_q, lock_d;

    logic        win_end;
    logic [16:0] err_eval;
    logic        win_bad;

    // The window-end cycle's own error event takes part in the verdict.
    assign win_end  = i_vld && (state_q != ST_HOLD) && (win_cnt_q == WIN_LAST);
    assign err_eval = {1'b0, err_cnt_q} + 17'(i_err);
    assign win_bad  = (err_eval >= ERR_LIMIT);

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        err_cnt_d  = err_cnt_q;
        hold_cnt_d = hold_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        slip_cnt_d = slip_cnt_q;
        sh_d       = 1'b0;

        if (i_resync) begin
            state_d    = ST_SEARCH;
            win_cnt_d  = '0;
            err_cnt_d  = '0;
            hold_cnt_d = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (state_q == ST_HOLD) begin
            if (i_vld) begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_SEARCH;
                    hold_cnt_d = '0;
                    win_cnt_d  = '0;
                    err_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
        end else if (win_end) begin
            win_cnt_d = '0;
            err_cnt_d = '0;
            if (state_q == ST_SEARCH) begin
                if (win_bad) begin
                    sh_d       = 1'b1;
                    slip_cnt_d = slip_cnt_q + 8'd1;
                    good_cnt_d = '0;
                    hold_cnt_d = '0;
                    state_d    = ST_HOLD;
                end else if (good_cnt_q == LOCK_LAST) begin
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                    state_d    = ST_LOCKED;
                end else begin
                    good_cnt_d = good_cnt_q + 8'd1;
                end
            end else begin
                // Losing lock does not slip: the phase was right until recently.
                if (!win_bad) begin
                    bad_cnt_d = '0;
                end else if (bad_cnt_q == UNLOCK_LAST) begin
                    bad_cnt_d  = '0;
                    good_cnt_d = '0;
                    state_d    = ST_SEARCH;
                end else begin
                    bad_cnt_d = bad_cnt_q + 8'd1;
                end
            end
        end else begin
            if (i_vld) begin
                win_cnt_d = win_cnt_q + 16'd1;
            end
            if (i_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        lock_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SEARCH;
            win_cnt_q  <= '0;
            err_cnt_q  <= '0;
            hold_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            slip_cnt_q <= '0;
            sh_q       <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            err_cnt_q  <= err_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            slip_cnt_q <= slip_cnt_d;
            sh_q       <= sh_d;
            lock_q     <= lock_d;
        end
    end

    assign o_sh_pointer = sh_q;
    assign o_lock       = lock_q;
    assign o_slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_deperf_sync_ctrl.sv
// Scoreboard bench for deperf_sync_ctrl using the small verification parameter set
// (window 8, threshold 3, lock/unlock after 2 windows, holdoff 4).
module tb_deperf_sync_ctrl;

    localparam int WIN_LEN    = 8;
    localparam int ERR_THR    = 3;
    localparam int LOCK_WIN   = 2;
    localparam int UNLOCK_WIN = 2;
    localparam int HOLDOFF    = 4;

    logic       clk;
    logic       reset_n;
    logic       i_vld;
    logic       i_err;
    logic       i_resync;
    logic       o_sh_pointer;
    logic       o_lock;
    logic [7:0] o_slip_cnt;

    deperf_sync_ctrl #(
        .WIN_LEN   (WIN_LEN),
        .ERR_THR   (ERR_THR),
        .LOCK_WIN  (LOCK_WIN),
        .UNLOCK_WIN(UNLOCK_WIN),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_vld       (i_vld),
        .i_err       (i_err),
        .i_resync    (i_resync),
        .o_sh_pointer(o_sh_pointer),
        .o_lock      (o_lock),
        .o_slip_cnt  (o_slip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sh;
        logic       lock;
        logic [7:0] slip;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp;
    int n_err;
    int sh_seen;

    // Reference model: 0 = SEARCH, 1 = HOLD, 2 = LOCKED
    int   m_state;
    int   m_win, m_err, m_good, m_bad, m_hold, m_slip;
    logic m_sh, m_lock;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_win = 0; m_err = 0; m_good = 0; m_bad = 0; m_hold = 0; m_slip = 0;
        m_sh = 1'b0; m_lock = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic e, input logic r);
        int eval;
        eval = m_err + int'(e);
        m_sh = 1'b0;
        if (r) begin
            m_state = 0;
            m_win = 0; m_err = 0; m_good = 0; m_bad = 0; m_hold = 0;
        end else if (m_state == 1) begin
            if (v) begin
                m_hold++;
                if (m_hold == HOLDOFF) begin
                    m_state = 0; m_hold = 0; m_win = 0; m_err = 0;
                end
            end
        end else if (v && m_win == WIN_LEN - 1) begin
            m_win = 0; m_err = 0;
            if (m_state == 0) begin
                if (eval >= ERR_THR) begin
                    m_sh = 1'b1; m_slip = (m_slip + 1) % 256; m_good = 0; m_state = 1;
                end else begin
                    m_good++;
                    if (m_good == LOCK_WIN) begin m_good = 0; m_state = 2; end
                end
            end else begin
                if (eval >= ERR_THR) begin
                    m_bad++;
                    if (m_bad == UNLOCK_WIN) begin m_bad = 0; m_state = 0; end
                end else begin
                    m_bad = 0;
                end
            end
        end else begin
            if (v) m_win++;
            if (e && m_err < 65535) m_err++;
        end
        m_lock = (m_state == 2);
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic v, input logic e, input logic r);
        exp_t ex;
        exp_t got;
        i_vld = v; i_err = e; i_resync = r;
        model_step(v, e, r);
        sb_q.push_back('{sh: m_sh, lock: m_lock, slip: 8'(m_slip)});
        @(posedge clk);
        #1;
        i_vld = 1'b0; i_err = 1'b0; i_resync = 1'b0;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 0, 1);
        end else begin
            ex  = sb_q.pop_front();
            got = '{sh: o_sh_pointer, lock: o_lock, slip: o_slip_cnt};
            check_val("sb_sh", int'(got.sh), int'(ex.sh));
            check_val("sb_lock", int'(got.lock), int'(ex.lock));
            check_val("sb_slip", int'(got.slip), int'(ex.slip));
        end
        if (o_sh_pointer) sh_seen++;
    endtask

    task automatic run_win(input logic [7:0] err_mask, input logic resync_last);
        for (int i = 0; i < WIN_LEN; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0);
            step(1'b1, err_mask[i], resync_last && (i == WIN_LEN - 1));
        end
    endtask

    task automatic run_strobes(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b1, e, 1'b0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_sh", int'(o_sh_pointer), 0);
        check_val("rst_lock", int'(o_lock), 0);
        check_val("rst_slip", int'(o_slip_cnt), 0);
        @(posedge clk);
        #1;
        check_val("rst_hold_slip", int'(o_slip_cnt), 0);
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; sh_seen = 0;
        i_vld = 1'b0; i_err = 1'b0; i_resync = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        step(1'b0, 1'b0, 1'b0);

        // V1: two clean windows lock the controller
        sh_seen = 0;
        run_win(8'h00, 1'b0);
        check_val("v1_no_lock_yet", int'(o_lock), 0);
        run_win(8'h00, 1'b0);
        check_val("v1_lock", int'(o_lock), 1);
        check_val("v1_no_slip", sh_seen, 0);

        // V3: two bad windows while locked drop lock without slipping
        sh_seen = 0;
        run_win(8'h07, 1'b0);
        check_val("v3_still_locked", int'(o_lock), 1);
        run_win(8'h07, 1'b0);
        check_val("v3_unlock", int'(o_lock), 0);
        check_val("v3_no_slip", sh_seen, 0);

        // V4a: errors on strobe 6, an idle cycle, and the window-end strobe total exactly 3
        sh_seen = 0;
        run_strobes(5, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_val("v4_bad_slip_pulse", int'(o_sh_pointer), 1);
        check_val("v4_slip_cnt", int'(o_slip_cnt), 1);
        run_strobes(HOLDOFF, 1'b1);
        check_val("v4_one_pulse", sh_seen, 1);

        // V4b: two errors including the window end is still a good window
        sh_seen = 0;
        run_win(8'hC0, 1'b0);
        check_val("v4_good_no_slip", sh_seen, 0);
        check_val("v4_good_slip_cnt", int'(o_slip_cnt), 1);

        // V2: bad window slips once; hold strobes ignore errors; fresh window follows
        sh_seen = 0;
        run_win(8'h07, 1'b0);
        check_val("v2_slip_cnt", int'(o_slip_cnt), 2);
        run_strobes(HOLDOFF, 1'b1);
        run_win(8'h00, 1'b0);
        check_val("v2_single_pulse", sh_seen, 1);
        check_val("v2_not_locked", int'(o_lock), 0);

        // V5: resync on a bad window end wins and clears good_cnt
        sh_seen = 0;
        run_win(8'h07, 1'b1);
        check_val("v5_no_slip", sh_seen, 0);
        check_val("v5_slip_cnt", int'(o_slip_cnt), 2);
        run_win(8'h00, 1'b0);
        check_val("v5_good_cleared", int'(o_lock), 0);
        run_win(8'h00, 1'b0);
        check_val("v5_relock", int'(o_lock), 1);

        // V6: reset in the middle of HOLD discards everything
        step(1'b0, 1'b0, 1'b1);
        check_val("v6_resync_unlock", int'(o_lock), 0);
        run_win(8'h07, 1'b0);
        check_val("v6_slip_cnt", int'(o_slip_cnt), 3);
        run_strobes(2, 1'b0);
        apply_reset();
        sh_seen = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_strobes(WIN_LEN - 4, 1'b0);
        check_val("v6_no_early_slip", sh_seen, 0);
        step(1'b1, 1'b0, 1'b0);
        check_val("v6_fresh_slip", sh_seen, 1);
        check_val("v6_slip_cnt_after", int'(o_slip_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
